// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the per-operation iteration count.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

endpackage

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle on magnitudes,
// sign correction in a final FIX cycle, plus direct MTHI/MTLO writes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int AW = 2 * WIDTH;
    localparam int SW = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    state_e state, state_next;
    logic [CNT_W-1:0] cnt;

    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_step;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             div_zero;

    logic signed [WIDTH-1:0] rs_s;
    logic signed [WIDTH-1:0] rt_s;
    logic             op_arith;
    logic             op_signed;
    logic             op_div;
    logic             idle_go;
    logic             take_arith;
    logic             take_mthi;
    logic             take_mtlo;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [SW-1:0]    add_sum;
    logic             fits;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [AW-1:0] cond_neg_wide(input logic [AW-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign rs_s = rs_data;
    assign rt_s = rt_data;
    assign busy = (state != IDLE);

    always_comb begin
        op_arith   = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        op_signed  = (op == OP_MULT) || (op == OP_DIV);
        op_div     = (op == OP_DIV) || (op == OP_DIVU);
        idle_go    = (state == IDLE) && start && !cancel;
        take_arith = idle_go && op_arith;
        take_mthi  = idle_go && (op == OP_MTHI);
        take_mtlo  = idle_go && (op == OP_MTLO);
        rs_neg     = op_signed && (rs_s < 0);
        rt_neg     = op_signed && (rt_s < 0);
        rs_mag     = cond_neg(rs_data, rs_neg);
        rt_mag     = cond_neg(rt_data, rt_neg);
    end

    // One shared adder: multiply adds the multiplicand into the upper half,
    // divide subtracts the divisor from the shifted remainder (carry-out = fits).
    always_comb begin
        rem_sh = acc[AW-1:WIDTH-1];
        if (is_div) begin
            add_a = rem_sh;
            add_b = ~{1'b0, opnd};
        end else begin
            add_a = {1'b0, acc[AW-1:WIDTH]};
            add_b = acc[0] ? {1'b0, opnd} : '0;
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + SW'(is_div);
        fits    = add_sum[SW-1];
        if (is_div) begin
            acc_step = {(fits ? add_sum[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        end else begin
            acc_step = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (take_arith) state_next = CALC;
            CALC:    if (cancel) state_next = IDLE;
                     else if (cnt == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control and architectural state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FIX) && !cancel;
            if (take_arith) begin
                cnt <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
            end
            if ((state == FIX) && !cancel) begin
                if (is_div) begin
                    lo <= div_zero ? '1 : cond_neg(acc[WIDTH-1:0], neg_lo);
                    hi <= cond_neg(acc[AW-1:WIDTH], neg_hi);
                end else begin
                    {hi, lo} <= cond_neg_wide(acc, neg_lo);
                end
            end else begin
                if (take_mthi) hi <= rs_data;
                if (take_mtlo) lo <= rs_data;
            end
        end
    end

    // Iteration datapath; quotient/multiplier bits live in the low half of acc
    always_ff @(posedge clk) begin
        if (take_arith) begin
            is_div   <= op_div;
            opnd     <= op_div ? rt_mag : rs_mag;
            acc      <= {{WIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
            neg_lo   <= rs_neg ^ rt_neg;
            neg_hi   <= op_div ? rs_neg : (rs_neg ^ rt_neg);
            div_zero <= op_div && (rt_data == '0);
        end else if (state == CALC) begin
            acc <= acc_step;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops, with
// results predicted by plain 64-bit arithmetic.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [2:0]  op      = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        cancel  = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_count = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_e;
    logic        done_prev = 1'b0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Returns {hi, lo} as defined for each operation
    function automatic logic [63:0] model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (code)
            OP_MULT:  return sa * sb;
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_arith(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [63:0] e;
        int cyc;
        e = model(code, a, b);
        sb_q.push_back(e);
        {exp_hi, exp_lo} = e;
        op = code; rs_data = a; rt_data = b; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            if (inject != 0 && cyc == inject) begin
                start = 1'b1; op = OP_MTHI; rs_data = $urandom; rt_data = $urandom;
            end
            if (inject != 0 && cyc == inject + 3) begin
                start = 1'b1; op = OP_DIVU; rs_data = $urandom; rt_data = $urandom;
            end
            step();
            start = 1'b0;
            cyc++;
        end
        chk("busy_cycles", cyc, 33);
        chk("done_with_result", done, 1'b1);
    endtask

    task automatic issue_only(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        op = code; rs_data = a; rt_data = b; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic mt_write(input logic [2:0] code, input logic [31:0] v);
        op = code; rs_data = v; rt_data = $urandom; start = 1'b1;
        step();
        start = 1'b0;
        if (code == OP_MTHI) exp_hi = v;
        else exp_lo = v;
        chk("mt_hi", hi, exp_hi);
        chk("mt_lo", lo, exp_lo);
        chk("mt_busy", busy, 1'b0);
        chk("mt_done", done, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                done_count++;
                chk("done_one_cycle", done_prev, 1'b0);
                chk("result_pending", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("hi", hi, mon_e[63:32]);
                    chk("lo", lo, mon_e[31:0]);
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    initial begin
        int dc;
        int sel;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        step();

        run_arith(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_arith(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 0);
        run_arith(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_arith(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 0);
        run_arith(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_arith(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 0);
        run_arith(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 0);

        // cancel during CALC
        mt_write(OP_MTHI, 32'h1234_5678);
        issue_only(OP_DIVU, 32'd10, 32'd3);
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_calc_busy", busy, 0);
        chk("cancel_calc_hi", hi, exp_hi);
        chk("cancel_calc_lo", lo, exp_lo);
        chk("cancel_calc_done", done, 0);
        dc = done_count;
        repeat (40) step();
        chk("no_done_after_cancel", done_count, dc);

        // cancel during FIX
        issue_only(OP_MULTU, 32'h0001_0001, 32'h0000_FFFF);
        repeat (32) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_fix_busy", busy, 0);
        chk("cancel_fix_hi", hi, exp_hi);
        chk("cancel_fix_lo", lo, exp_lo);
        chk("cancel_fix_done", done, 0);
        step();
        chk("no_done_after_fix_cancel", done_count, dc);

        // asynchronous reset mid-CALC
        mt_write(OP_MTLO, 32'hA5A5_5A5A);
        issue_only(OP_DIVU, 32'd1000, 32'd7);
        repeat (15) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        exp_hi = '0;
        exp_lo = '0;
        step();
        rst_n = 1'b1;
        step();
        run_arith(OP_DIVU, 32'd7, 32'd7, 0);

        // start while busy is ignored
        run_arith(OP_MULT, $urandom, $urandom, 5);
        run_arith(OP_DIVU, $urandom, $urandom | 32'h1, 12);

        // start coincident with cancel in IDLE
        op = OP_DIV; rs_data = 32'd50; rt_data = 32'd5; start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel_busy", busy, 0);
        op = OP_MTHI; rs_data = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
        step();
        start = 1'b0; cancel = 1'b0;
        chk("mthi_cancel_hi", hi, exp_hi);

        // undefined op codes
        for (int k = 6; k < 8; k++) begin
            op = 3'(k); rs_data = $urandom; rt_data = $urandom; start = 1'b1;
            step();
            start = 1'b0;
            chk("undef_busy", busy, 0);
            chk("undef_hi", hi, exp_hi);
            chk("undef_lo", lo, exp_lo);
            step();
            chk("undef_done", done, 0);
        end

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            a = rand_word();
            b = rand_word();
            if (sel < 4) run_arith(3'(sel), a, b, 0);
            else mt_write((sel == 4) ? OP_MTHI : OP_MTLO, a);
        end

        step();
        step();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
